// File: rtl/dit_pkg.sv
// Shared types and helpers for the ping-pong DIT input store.
// The drop-on-overflow variant is selected with DIT_STORE_DROP_EN.
package dit_pkg;
  localparam int DATA_W_DEF = 12;
  localparam int N_LOG2_DEF = 4;
  localparam int N_LOG2_MAX = 10;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  // Reverses the low nbits bits of idx; bits above nbits come back zero.
  function automatic logic [N_LOG2_MAX-1:0] bitrev(input logic [N_LOG2_MAX-1:0] idx,
                                                  input int nbits);
    logic [N_LOG2_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < N_LOG2_MAX; i++)
      if (i < nbits) r[nbits-1-i] = idx[i];
    return r;
  endfunction
endpackage

// File: rtl/dit_bank_ram.sv
// One frame bank: N x DATA_W storage, one write port, one registered read port.
// Only the read register is reset; the array contents are not.
module dit_bank_ram import dit_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [N_LOG2-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [N_LOG2-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [2**N_LOG2];

  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;

  always_ff @(posedge clk)
    if (rst)     rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/dit_store_pp.sv
// Ping-pong DIT input store: samples land at bit-reversed addresses, FFT reads naturally.
// Define DIT_STORE_DROP_EN to drop samples on overflow instead of back-pressuring.
module dit_store_pp import dit_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_en,
  input  logic [N_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_ready,
  input  logic              frame_release,
  output logic [7:0]        frame_count
`ifdef DIT_STORE_DROP_EN
  ,
  output logic [15:0]       drop_count
`endif
);
  localparam int N = 2**N_LOG2;

  bank_state_t bank_st [2];
  bank_state_t st_n [2];
  logic wr_bank, wr_bank_n, rd_bank, rd_bank_n, rd_sel, other;
  logic [N_LOG2-1:0] wr_ptr, wa;
  logic writable, xfer, done, rel, rd_go;
  logic [1:0] we, re;
  logic [1:0][DATA_W-1:0] rd_q;

  assign other       = ~wr_bank;
  assign writable    = (bank_st[wr_bank] == FILLING);
  assign frame_ready = (bank_st[0] == FULL) || (bank_st[1] == FULL);
`ifdef DIT_STORE_DROP_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = writable;
`endif
  // With in_ready tied high, an unwritable cycle is a drop rather than a stall.
  assign xfer  = in_valid & writable;
  assign done  = xfer && (wr_ptr == N_LOG2'(N-1));
  assign rel   = frame_release & frame_ready;
  assign rd_go = rd_en & frame_ready;
  assign wa    = N_LOG2'(bitrev(N_LOG2_MAX'(wr_ptr), N_LOG2));

  always_comb begin
    st_n[0]   = bank_st[0];
    st_n[1]   = bank_st[1];
    wr_bank_n = wr_bank;
    rd_bank_n = rd_bank;
    if (rel) begin
      st_n[rd_bank] = EMPTY;
      rd_bank_n     = ~rd_bank;
    end
    if (done) begin
      st_n[wr_bank] = FULL;
      // The just-completed frame is oldest unless the other bank still holds one.
      if (st_n[other] != FULL) rd_bank_n = wr_bank;
      if (st_n[other] == EMPTY) begin
        st_n[other] = FILLING;
        wr_bank_n   = other;
      end
    end else if (rel && bank_st[wr_bank] == FULL) begin
      st_n[rd_bank] = FILLING;
      wr_bank_n     = rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0]  <= FILLING;
      bank_st[1]  <= EMPTY;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_ptr      <= '0;
      frame_count <= '0;
      rd_valid    <= 1'b0;
      rd_sel      <= 1'b0;
    end else begin
      bank_st[0] <= st_n[0];
      bank_st[1] <= st_n[1];
      wr_bank    <= wr_bank_n;
      rd_bank    <= rd_bank_n;
      if (xfer) wr_ptr <= done ? '0 : wr_ptr + 1'b1;
      if (done) frame_count <= frame_count + 8'd1;
      rd_valid <= rd_go;
      if (rd_go) rd_sel <= rd_bank;
    end
  end

`ifdef DIT_STORE_DROP_EN
  always_ff @(posedge clk)
    if (rst) drop_count <= '0;
    else if (in_valid && !writable && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we[b] = xfer  && (wr_bank == 1'(b));
    assign re[b] = rd_go && (rd_bank == 1'(b));
    dit_bank_ram #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) u_ram (
      .clk(clk), .rst(rst),
      .we(we[b]), .wa(wa), .wd(in_data),
      .re(re[b]), .ra(rd_addr), .rd(rd_q[b])
    );
  end

  // rd_sel only moves on a real read, so rd_data holds between reads.
  assign rd_data = rd_q[rd_sel];
endmodule

// File: tb/tb_dit_store_pp.sv
// Directed bench for dit_store_pp with a frame-queue reference model checked every cycle.
// Build with DIT_STORE_DROP_EN defined to exercise the drop variant.
module tb_dit_store_pp;
  localparam int DW = 12;
  localparam int NL = 4;
  localparam int N  = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, rd_en = 1'b0, frame_release = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [NL-1:0] rd_addr = '0;
  logic in_ready, rd_valid, frame_ready;
  logic [DW-1:0] rd_data;
  logic [7:0] frame_count;
`ifdef DIT_STORE_DROP_EN
  logic [15:0] drop_count;
`endif

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int lit [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  dit_store_pp #(.DATA_W(DW), .N_LOG2(NL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_ready(frame_ready), .frame_release(frame_release), .frame_count(frame_count)
`ifdef DIT_STORE_DROP_EN
    , .drop_count(drop_count)
`endif
  );

  // Reference: a queue of completed frames (oldest first) plus the frame being assembled.
  typedef logic [DW-1:0] frame_t [N];
  frame_t full_q [$];
  frame_t part;
  int wptr, m_fc, m_drop, nfull;
  logic [DW-1:0] m_rd;
  bit m_rv;

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < NL; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      full_q.delete();
      wptr = 0; m_fc = 0; m_drop = 0; m_rd = '0; m_rv = 1'b0;
    end else begin
      nfull = full_q.size();
      m_rv  = rd_en && nfull > 0;
      if (m_rv) m_rd = full_q[0][rd_addr];
      if (frame_release && nfull > 0) void'(full_q.pop_front());
      if (in_valid && nfull < 2) begin
        part[brev(wptr)] = in_data;
        wptr++;
        if (wptr == N) begin
          full_q.push_back(part);
          wptr = 0;
          m_fc = (m_fc + 1) % 256;
        end
      end else if (in_valid && m_drop < 65535) m_drop++;
    end
  end

  always @(negedge clk) if (chk_en) begin
`ifdef DIT_STORE_DROP_EN
    chk("m_in_ready", in_ready, 1);
    chk("m_drop_count", drop_count, m_drop);
`else
    chk("m_in_ready", in_ready, full_q.size() < 2);
`endif
    chk("m_frame_ready", frame_ready, full_q.size() > 0);
    chk("m_frame_count", frame_count, m_fc);
    chk("m_rd_valid", rd_valid, m_rv);
    chk("m_rd_data", rd_data, m_rd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; rd_en = 1'b0; frame_release = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = DW'(v);
    step();
    in_valid = 1'b0;
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    step();
    frame_release = 1'b0;
  endtask

  task automatic read_frame(input int base, input string tag);
    for (int a = 0; a < N; a++) begin
      rd_en   = 1'b1;
      rd_addr = NL'(a);
      step();
      chk({tag, "_rd_valid"}, rd_valid, 1);
      chk({tag, "_rd_data"}, rd_data, base + lit[a]);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    // 1: reset state, one frame, natural-order readout of bit-reversed data
    do_reset();
    chk_en = 1'b1;
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    for (int i = 0; i < N; i++) begin
      send(i);
      if (i == N-2) chk("t1_ready_early", frame_ready, 0);
    end
    chk("t1_frame_ready", frame_ready, 1);
    chk("t1_frame_count", frame_count, 1);
    read_frame(0, "t1");
    release_frame();
    chk("t1_released", frame_ready, 0);

    // 5: read and release with nothing ready are ignored
    rd_en = 1'b1; frame_release = 1'b1;
    step();
    rd_en = 1'b0; frame_release = 1'b0;
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_rd_data_held", rd_data, 15);
    chk("t5_frame_count", frame_count, 1);
    chk("t5_in_ready", in_ready, 1);

`ifndef DIT_STORE_DROP_EN
    // 2: back-pressure with both banks full, then release to resume
    do_reset();
    for (int i = 0; i < 2*N; i++) send(16 + i);
    chk("t2_stalled", in_ready, 0);
    in_valid = 1'b1; in_data = DW'(48);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_hold_stall", in_ready, 0);
    end
    release_frame();
    chk("t2_resumed", in_ready, 1);
    for (int i = 0; i < N; i++) send(48 + i);
    chk("t2_restall", in_ready, 0);
    chk("t2_frame_count", frame_count, 3);
    read_frame(32, "t2f2");
    release_frame();
    read_frame(48, "t2f3");
    release_frame();
`endif

    // 3: release on the same edge as a frame completion
    do_reset();
    for (int i = 0; i < N; i++) send(100 + i);
    for (int i = 0; i < N-1; i++) send(200 + i);
    frame_release = 1'b1;
    send(200 + N-1);
    frame_release = 1'b0;
    chk("t3_frame_ready", frame_ready, 1);
    chk("t3_in_ready", in_ready, 1);
    chk("t3_frame_count", frame_count, 2);
    read_frame(200, "t3");
    release_frame();

    // 4: reset mid-frame discards the partial frame
    do_reset();
    for (int i = 0; i < 7; i++) send(12'hA00 + i);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_rst_count", frame_count, 0);
    for (int i = 0; i < N; i++) begin
      chk("t4_not_ready", frame_ready, 0);
      send(300 + i);
    end
    chk("t4_frame_ready", frame_ready, 1);
    read_frame(300, "t4");

`ifdef DIT_STORE_DROP_EN
    // 6: overflow drops samples, both stored frames stay intact
    do_reset();
    for (int i = 0; i < 40; i++) begin
      chk("t6_in_ready", in_ready, 1);
      send(400 + i);
    end
    chk("t6_drop_count", drop_count, 8);
    chk("t6_frame_count", frame_count, 2);
    read_frame(400, "t6f1");
    release_frame();
    read_frame(416, "t6f2");
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
